ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//  Initiator side of the 4-bit scratch-RAM bus. Accepts one read/write request at a time from the CPU datapath.
//  Sequences chips / enableRW / oprnd / program_byte and the bidirectional data nibble so that the level-sensitive RAM sees stable address and data around every strobe.
//  Returns read data with a one-cycle response pulse. Sits between the control unit and the RAM, one instance per RAM.
// PARAMETERS
//  WAIT_STATES  1  extra cycles chips is held high beyond the first (range 0..15)
// PORTS
//  clock         in     1   system clock; all state changes on rising edge
//  reset         in     1   asynchronous, active-high reset
//  req_valid     in     1   request present
//  req_ready     out    1   high when a request can be accepted (state IDLE)
//  req_write     in     1   1 = write, 0 = read
//  req_addr      in     12  nibble address; [11:8] -> oprnd, [7:0] -> program_byte
//  req_wdata     in     4   write nibble
//  rsp_valid     out    1   one-cycle pulse: transaction finished
//  rsp_rdata     out    4   read nibble; held until next read completes
//  busy          out    1   high in any state other than IDLE
//  chips         out    1   RAM chip select
//  enableRW      out    1   RAM mode: 1 = write, 0 = read
//  oprnd         out    4   address high nibble
//  program_byte  out    8   address low byte
//  data          inout  4   shared data nibble, driven here only for writes
// BEHAVIOUR
//  - Clocking and reset: one clock. Reset is asynchronous and active-high.
//  - Reset values: state=IDLE, chips=0, enableRW=0, oprnd=0, program_byte=0, data=4'bz, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1.
//  - Handshake:
//    - Transfer occurs when req_valid && req_ready on a clock edge.
//    - addr, write and wdata are captured at that edge; later changes on req_* are ignored.
//  - FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE. ACCESS lasts WAIT_STATES+1 cycles, counted by a 4-bit counter.
//    - IDLE: chips=0, enableRW=0, data=z. Leave IDLE only on an accepted request.
//    - SETUP: oprnd/program_byte show the captured address; enableRW=captured write; chips=0. For a write, data is driven with wdata.
//    - ACCESS: chips=1, address and enableRW unchanged. For a write, data is driven. For a read, data is sampled on the last ACCESS edge into rsp_rdata.
//    - HOLD: chips=0, address unchanged. For a write, data stays driven (hold time). rsp_valid=1 for exactly this cycle.
//  - Tri-state rule: data is driven iff the captured write is 1 and the state is SETUP, ACCESS or HOLD. Otherwise data=4'bz.
//  - No-contention invariants:
//    - Never chips=1 with enableRW=0 while data is being driven.
//    - enableRW changes only while chips=0.
//  - Latency: accept at edge N; chips high over edges N+1 .. N+1+WAIT_STATES; rsp_valid high in cycle N+3+WAIT_STATES.
//  - Throughput: one transaction per 4+WAIT_STATES cycles (IDLE is mandatory between transactions; it provides bus turnaround).
//  - rsp_rdata updates only on reads. A write completion leaves it unchanged.
//  - Reset mid-operation: all outputs return to reset values immediately and the bus is released. An interrupted write may leave a partial nibble in RAM; this is accepted. No rsp_valid is issued for the aborted request.
//  - req_valid held high through the HOLD cycle: the request is accepted in the following IDLE cycle, never in HOLD.
//  - Address wrap: none. 12'hFFF is a legal address, and the next request is independent.
// STRUCTURE
//  - Shared include ram_bus_defs.vh: RAM_ADDR_W=12, RAM_DATA_W=4, state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, HOLD=2'd3).
//  - The RAM model and the control unit also use these definitions.
//  - One flat module: FSM, wait counter, capture registers, tri-state assign. No sub-module is needed.
// TESTING
//  - Bench pairs ram_bus_master with the existing 4-bit RAM model.
//  1. Write 4'hA @12'h3C5, then read @12'h3C5. Required: oprnd=4'h3, program_byte=8'hC5, rsp_rdata=4'hA; rsp_valid 3 cycles after each accept (WAIT_STATES=0).
//  2. WAIT_STATES=2: read @12'hFFF after writing 4'h5. Required: chips high for exactly 3 cycles, rsp_valid at accept+5, rsp_rdata=4'h5.
//  3. Back-to-back requests with req_valid held high: write 1..4 @12'h000..003. Required: req_ready low during SETUP/ACCESS/HOLD, one accept per 4 cycles, readback 1,2,3,4.
//  4. Assertion every cycle: no contention, i.e. !(data driven && chips && !enableRW); no enableRW edge while chips=1.
//  5. Assert reset during ACCESS of a write 4'h7 @12'h010. Required: same cycle chips=0, data=z, busy=0; no rsp_valid; next request proceeds normally.
//  6. Change req_addr/req_wdata one cycle after accept (to 12'h999 / 4'hF). Required: the RAM still sees the captured 12'h123 / 4'h6.

Source files
------------

// File: rtl/ram_bus_master_pkg.sv
// Shared scratch-RAM bus definitions: address/data widths, master FSM states, captured request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_bus_master_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 4;

  // Bus sequencing states; the encodings are shared with the RAM model and control unit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Request as captured at the accepting edge.
  typedef struct packed {
    logic                  write;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_bus_master_if.sv
// Request/response handshake plus RAM control/address lines of one scratch-RAM bus.
// Latency: n/a (wiring only).
// Backpressure: req_ready is driven by the master; the requester must hold req_* until accepted.
interface ram_bus_master_if;
  import ram_bus_master_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [RAM_ADDR_W-1:0] req_addr;
  logic [RAM_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic [RAM_DATA_W-1:0] rsp_rdata;
  logic                  busy;
  logic                  chips;
  logic                  enableRW;
  logic [3:0]            oprnd;
  logic [7:0]            program_byte;

  // Bus master view (the ram_bus_master itself).
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output chips, enableRW, oprnd, program_byte
  );

  // Requester / observer view.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  chips, enableRW, oprnd, program_byte
  );

endinterface

// File: rtl/ram_bus_master.sv
// Sequences one read/write onto the level-sensitive 4-bit scratch RAM: SETUP, ACCESS, HOLD, IDLE.
// Latency: accept at edge N, rsp_valid high in the cycle ending at edge N+3+WAIT_STATES.
// Backpressure: req_ready only in IDLE, so one transaction per 4+WAIT_STATES cycles.
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int WAIT_STATES = 1   // extra ACCESS cycles, 0..15
) (
  input  logic                  clock,
  input  logic                  reset,
  ram_bus_master_if.master      bus,
  inout  wire  [RAM_DATA_W-1:0] data
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t                state;
  state_t                state_nxt;
  req_t                  cap;
  logic [3:0]            wait_cnt;
  logic [RAM_DATA_W-1:0] rdata_q;
  logic                  access_last;
  logic                  drive_data;

  // ACCESS ends once the counter has covered the configured wait states.
  assign access_last = (state == ACCESS) && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and strobes: chips only in ACCESS, so address and enableRW are
  // already stable for a full cycle before the strobe and stay for one after it.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.chips     = 1'b0;
    bus.enableRW  = cap.write;
    bus.rsp_valid = 1'b0;
    drive_data    = cap.write;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        bus.enableRW  = 1'b0;
        drive_data    = 1'b0;
        if (bus.req_valid) state_nxt = SETUP;
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        bus.chips = 1'b1;
        if (access_last) state_nxt = HOLD;
      end
      HOLD: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on the accepting edge; later req_* changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             cap <= '0;
    else if (state == IDLE && bus.req_valid) cap <= '{write: bus.req_write,
                                                      addr:  bus.req_addr,
                                                      wdata: bus.req_wdata};
  end

  // Wait-state counter: counts ACCESS cycles, cleared everywhere else.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (state == ACCESS)  wait_cnt <= wait_cnt + 4'd1;
    else                       wait_cnt <= '0;
  end

  // Read data is sampled on the last ACCESS edge and held until the next read completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          rdata_q <= '0;
    else if (access_last && !cap.write) rdata_q <= data;
  end

  assign bus.rsp_rdata    = rdata_q;
  assign bus.oprnd        = cap.addr[11:8];
  assign bus.program_byte = cap.addr[7:0];

  // The data nibble is only ours from SETUP through HOLD of a write.
  assign data = drive_data ? cap.wdata : {RAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench: two masters (WAIT_STATES 0 and 2), each with its own behavioural RAM, driven by shared request lines.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen.
module tb_ram_bus_master;
  import ram_bus_master_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ram_bus_master_if if0();
  ram_bus_master_if if2();
  wire [3:0] data0;
  wire [3:0] data2;

  ram_bus_master #(.WAIT_STATES(0)) dut0 (.clock(clock), .reset(reset), .bus(if0.master), .data(data0));
  ram_bus_master #(.WAIT_STATES(2)) dut2 (.clock(clock), .reset(reset), .bus(if2.master), .data(data2));

  int vectors = 0;
  int miscompares = 0;

  // Shared request lines, steered to one master by sel2.
  logic        sel2 = 1'b0;
  logic        r_valid = 1'b0;
  logic        r_write = 1'b0;
  logic [11:0] r_addr = '0;
  logic [3:0]  r_wdata = '0;
  assign if0.req_valid = r_valid && !sel2;
  assign if2.req_valid = r_valid && sel2;
  assign if0.req_write = r_write;
  assign if2.req_write = r_write;
  assign if0.req_addr  = r_addr;
  assign if2.req_addr  = r_addr;
  assign if0.req_wdata = r_wdata;
  assign if2.req_wdata = r_wdata;

  // Observed outputs of the selected master.
  wire        o_ready = sel2 ? if2.req_ready : if0.req_ready;
  wire        o_busy  = sel2 ? if2.busy : if0.busy;
  wire        o_chips = sel2 ? if2.chips : if0.chips;
  wire        o_en    = sel2 ? if2.enableRW : if0.enableRW;
  wire        o_rsp   = sel2 ? if2.rsp_valid : if0.rsp_valid;
  wire [3:0]  o_rdata = sel2 ? if2.rsp_rdata : if0.rsp_rdata;
  wire [11:0] o_addr  = sel2 ? {if2.oprnd, if2.program_byte} : {if0.oprnd, if0.program_byte};
  wire        o_drive = sel2 ? dut2.drive_data : dut0.drive_data;

  // Behavioural RAMs: drive data while selected for read, store the nibble on clock edges while selected for write.
  logic       ram_init = 1'b1;
  logic [3:0] ram0 [4096];
  logic [3:0] ram2 [4096];
  assign data0 = (if0.chips && !if0.enableRW) ? ram0[{if0.oprnd, if0.program_byte}] : 4'bz;
  assign data2 = (if2.chips && !if2.enableRW) ? ram2[{if2.oprnd, if2.program_byte}] : 4'bz;
  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) begin ram0[i] <= 4'h0; ram2[i] <= 4'h0; end
    end else begin
      if (if0.chips && if0.enableRW) ram0[{if0.oprnd, if0.program_byte}] <= data0;
      if (if2.chips && if2.enableRW) ram2[{if2.oprnd, if2.program_byte}] <= data2;
    end
  end

  // Reference model: expected RAM contents per master (unwritten locations read 0).
  logic [3:0] m0 [int];
  logic [3:0] m2 [int];
  function automatic logic [3:0] model_rd(input logic w2, input logic [11:0] a);
    if (w2) return m2.exists(int'(a)) ? m2[int'(a)] : 4'h0;
    return m0.exists(int'(a)) ? m0[int'(a)] : 4'h0;
  endfunction
  task automatic model_wr(input logic w2, input logic [11:0] a, input logic [3:0] d);
    if (w2) m2[int'(a)] = d;
    else    m0[int'(a)] = d;
  endtask

  // Bus invariants every cycle on both masters.
  logic p_chips0 = 1'b0, p_en0 = 1'b0, p_chips2 = 1'b0, p_en2 = 1'b0;
  always @(negedge clock) begin
    vectors += 2;
    if (dut0.drive_data && if0.chips && !if0.enableRW) begin miscompares++; $display("FAIL contention0 t=%0t drive=1 chips=1 enableRW=0, required no drive", $time); end
    if (dut2.drive_data && if2.chips && !if2.enableRW) begin miscompares++; $display("FAIL contention2 t=%0t drive=1 chips=1 enableRW=0, required no drive", $time); end
    if (p_chips0 && if0.chips && (if0.enableRW !== p_en0)) begin miscompares++; $display("FAIL en_edge0 t=%0t enableRW %b->%b while chips=1, required stable", $time, p_en0, if0.enableRW); end
    if (p_chips2 && if2.chips && (if2.enableRW !== p_en2)) begin miscompares++; $display("FAIL en_edge2 t=%0t enableRW %b->%b while chips=1, required stable", $time, p_en2, if2.enableRW); end
    p_chips0 <= if0.chips; p_en0 <= if0.enableRW;
    p_chips2 <= if2.chips; p_en2 <= if2.enableRW;
  end

  // One transaction on the selected master; starts and ends just after a falling edge.
  // lat counts rising edges from the accepting edge to the first cycle showing rsp_valid.
  task automatic do_txn(input logic wr, input logic [11:0] a, input logic [3:0] wd, input logic scramble,
                        output logic [3:0] rd, output int lat, output int chips_n, output int addr_bad,
                        output int drv_n, output logic rsp_next, output logic idle_ok, output logic timeout);
    int g;
    rd = '0; lat = 0; chips_n = 0; addr_bad = 0; drv_n = 0; rsp_next = 1'b0; idle_ok = 1'b0; timeout = 1'b0;
    r_valid = 1'b1; r_write = wr; r_addr = a; r_wdata = wd;
    g = 0;
    while (!o_ready && g < 50) begin @(negedge clock); g++; end
    if (!o_ready) begin timeout = 1'b1; r_valid = 1'b0; return; end
    @(posedge clock);
    if (wr) model_wr(sel2, a, wd);
    #1 r_valid = 1'b0;
    if (scramble) begin r_addr = 12'h999; r_wdata = 4'hF; r_write = 1'b1; end
    g = 0;
    while (1) begin
      @(negedge clock);
      if (o_busy) begin
        if (o_chips) chips_n++;
        if (o_drive) drv_n++;
        if (o_addr !== a) addr_bad++;
      end
      if (o_rsp) begin rd = o_rdata; break; end
      if (g >= 40) begin timeout = 1'b1; break; end
      @(posedge clock); lat++; g++;
    end
    @(negedge clock);
    rsp_next = o_rsp;
    idle_ok  = !o_busy && o_ready && !o_chips && !o_en && !o_drive;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      sel2 = (s == 1);
      #1;
      vectors += 3;
      if ({o_ready, o_busy, o_chips, o_en, o_rsp, o_drive} !== 6'b100000) begin miscompares++; $display("FAIL reset_ctrl dut%0d got rdy,busy,chips,en,rsp,drv=%b, required 100000", s * 2, {o_ready, o_busy, o_chips, o_en, o_rsp, o_drive}); end
      if (o_addr !== 12'h000) begin miscompares++; $display("FAIL reset_addr dut%0d got %h, required 000", s * 2, o_addr); end
      if (o_rdata !== 4'h0) begin miscompares++; $display("FAIL reset_rdata dut%0d got %h, required 0", s * 2, o_rdata); end
    end
    sel2 = 1'b0;
  endtask

  // Write then read the same location; checks latency, strobe length, address and data.
  task automatic check_pair(input logic use2, input logic [11:0] a, input logic [3:0] d, input string nm);
    logic [3:0] rd; int lat, cn, ab, dn; logic rn, io, to; int ws;
    sel2 = use2; ws = use2 ? 2 : 0;
    for (int k = 0; k < 2; k++) begin
      do_txn(k == 0, a, d, 1'b0, rd, lat, cn, ab, dn, rn, io, to);
      vectors += 6;
      if (to) begin miscompares++; $display("FAIL %s_timeout op%0d: no accept/response within budget", nm, k); end
      if (lat != ws + 2) begin miscompares++; $display("FAIL %s_latency op%0d got %0d edges after accept, required %0d", nm, k, lat, ws + 2); end
      if (cn != ws + 1) begin miscompares++; $display("FAIL %s_chips op%0d got %0d cycles, required %0d", nm, k, cn, ws + 1); end
      if (ab != 0) begin miscompares++; $display("FAIL %s_addr op%0d got %0d wrong-address cycles, required 0", nm, k, ab); end
      if (dn != ((k == 0) ? ws + 3 : 0)) begin miscompares++; $display("FAIL %s_drive op%0d got %0d driven cycles, required %0d", nm, k, dn, (k == 0) ? ws + 3 : 0); end
      if (rn || !io) begin miscompares++; $display("FAIL %s_pulse op%0d got rsp_next=%b idle=%b, required 0/1", nm, k, rn, io); end
    end
    vectors++;
    if (rd !== d) begin miscompares++; $display("FAIL %s_rdata got %h, required %h", nm, rd, d); end
  endtask

  task automatic test_basic;
    check_pair(1'b0, 12'h3C5, 4'hA, "basic");
  endtask

  task automatic test_wait_states;
    check_pair(1'b1, 12'hFFF, 4'h5, "wait2");
  endtask

  task automatic test_back_to_back;
    int acc[$]; int cyc, low_n; logic pr; logic [3:0] rd; int lat, cn, ab, dn; logic rn, io, to;
    sel2 = 1'b0; r_valid = 1'b1; r_write = 1'b1; r_addr = 12'h000; r_wdata = 4'h1;
    cyc = 0; low_n = 0;
    while (acc.size() < 4 && cyc < 60) begin
      pr = o_ready;
      if (acc.size() > 0 && !o_ready) low_n++;
      @(posedge clock); cyc++;
      if (pr) begin
        acc.push_back(cyc);
        model_wr(1'b0, r_addr, r_wdata);
        #1;
        if (acc.size() < 4) begin r_addr = r_addr + 12'd1; r_wdata = r_wdata + 4'd1; end
        else r_valid = 1'b0;
      end
      @(negedge clock);
    end
    r_valid = 1'b0;
    vectors += 2;
    if (acc.size() != 4) begin miscompares++; $display("FAIL b2b_accepts got %0d, required 4", acc.size()); end
    if (low_n != 9) begin miscompares++; $display("FAIL b2b_ready_low got %0d low cycles, required 9", low_n); end
    for (int i = 1; i < acc.size(); i++) begin
      vectors++;
      if (acc[i] - acc[i-1] != 4) begin miscompares++; $display("FAIL b2b_spacing %0d got %0d cycles, required 4", i, acc[i] - acc[i-1]); end
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, 12'(i), 4'h0, 1'b0, rd, lat, cn, ab, dn, rn, io, to);
      vectors++;
      if (to || rd !== 4'(i + 1)) begin miscompares++; $display("FAIL b2b_readback @%0d got %h (timeout=%b), required %h", i, rd, to, 4'(i + 1)); end
    end
  endtask

  task automatic test_capture;
    logic [3:0] rd; int lat, cn, ab, dn; logic rn, io, to;
    sel2 = 1'b0;
    do_txn(1'b1, 12'h123, 4'h6, 1'b1, rd, lat, cn, ab, dn, rn, io, to);
    vectors += 3;
    if (to || ab != 0) begin miscompares++; $display("FAIL capture_addr got %0d wrong-address cycles (timeout=%b), required 0", ab, to); end
    if (ram0[12'h123] !== 4'h6) begin miscompares++; $display("FAIL capture_ram123 got %h, required 6", ram0[12'h123]); end
    if (ram0[12'h999] !== model_rd(1'b0, 12'h999)) begin miscompares++; $display("FAIL capture_ram999 got %h, required %h", ram0[12'h999], model_rd(1'b0, 12'h999)); end
  endtask

  task automatic test_random(input logic use2);
    logic [11:0] written[$]; logic [11:0] a; logic [3:0] wd, ex, rd; logic wr;
    int lat, cn, ab, dn, ws; logic rn, io, to;
    sel2 = use2; ws = use2 ? 2 : 0;
    for (int i = 0; i < 30; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      if (!wr && written.size() > 0 && $urandom_range(0, 3) != 0) a = written[$urandom_range(0, written.size() - 1)];
      else a = 12'($urandom_range(0, 4095));
      wd = 4'($urandom_range(0, 15));
      ex = model_rd(use2, a);
      do_txn(wr, a, wd, 1'b0, rd, lat, cn, ab, dn, rn, io, to);
      if (wr) written.push_back(a);
      vectors += 4;
      if (to || lat != ws + 2) begin miscompares++; $display("FAIL rand%0d_latency #%0d got %0d (timeout=%b), required %0d", ws, i, lat, to, ws + 2); end
      if (cn != ws + 1 || ab != 0) begin miscompares++; $display("FAIL rand%0d_strobe #%0d got chips=%0d badaddr=%0d, required %0d/0", ws, i, cn, ab, ws + 1); end
      if (dn != (wr ? ws + 3 : 0)) begin miscompares++; $display("FAIL rand%0d_drive #%0d got %0d, required %0d", ws, i, dn, wr ? ws + 3 : 0); end
      if (rn || !io) begin miscompares++; $display("FAIL rand%0d_pulse #%0d got rsp_next=%b idle=%b, required 0/1", ws, i, rn, io); end
      if (wr) continue;
      vectors++;
      if (rd !== ex) begin miscompares++; $display("FAIL rand%0d_rdata #%0d @%h got %h, required %h", ws, i, a, rd, ex); end
    end
  endtask

  // Reset in the middle of ACCESS of a write; the aborted location is not read afterwards.
  task automatic test_reset_abort;
    int g; logic seen; logic [3:0] rd; int lat, cn, ab, dn; logic rn, io, to;
    sel2 = 1'b0; r_valid = 1'b1; r_write = 1'b1; r_addr = 12'h010; r_wdata = 4'h7;
    g = 0;
    while (!o_ready && g < 50) begin @(negedge clock); g++; end
    @(posedge clock); #1 r_valid = 1'b0;
    g = 0;
    while (!o_chips && g < 20) begin @(negedge clock); g++; end
    vectors++;
    if (!o_chips) begin miscompares++; $display("FAIL abort_reach got chips=0, required ACCESS reached"); end
    #1 reset = 1'b1;
    #1;
    vectors += 2;
    if ({o_chips, o_drive, o_busy, o_en, o_rsp, o_ready} !== 6'b000001) begin miscompares++; $display("FAIL abort_release got chips,drv,busy,en,rsp,rdy=%b, required 000001", {o_chips, o_drive, o_busy, o_en, o_rsp, o_ready}); end
    if (o_addr !== 12'h000) begin miscompares++; $display("FAIL abort_addr got %h, required 000", o_addr); end
    @(negedge clock); reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clock); if (o_rsp) seen = 1'b1; end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_rsp got rsp_valid=1 after abort, required none"); end
    check_pair(1'b0, 12'h011, 4'h3, "after_abort");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    test_reset();
    ram_init = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    test_basic();
    test_wait_states();
    test_back_to_back();
    test_capture();
    test_random(1'b0);
    test_random(1'b1);
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
